delay_line_vec: RTL

//  Parametrised multi-stage vector delay line for the DSP filter datapath.
//  - Delays two paired sample vectors (a, b; VECTOR lanes each) by a runtime-selectable 1..DEPTH cycles.
//  - Provides the z^-k state storage for feedforward/feedback paths of IIR/FIR sections.
//  - Adds stall, synchronous flush, valid tracking and a primed flag on top of the single-stage element.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/delay_stage_vec.sv | 36 +++
 rtl/delay_line_vec.sv | 89 ++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP datapath types and the tap-select delay clamp used by delay lines.
package dsp_pkg;

  localparam int DSP_REG_WIDTH = 16;
  localparam int DSP_VECTOR    = 2;

  typedef logic [DSP_REG_WIDTH-1:0] sample_t;
  typedef sample_t [DSP_VECTOR-1:0] sample_vec_t;

  // Requested delay of 0 means "shortest", anything past the chain means "longest".
  function automatic int unsigned clamp_dly(input int unsigned sel, input int unsigned depth);
    if (sel == 0) begin
      return 1;
    end else if (sel > depth) begin
      return depth;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/delay_stage_vec.sv
// One register stage of the vector delay line: holds paired a/b vectors plus a valid bit.
module delay_stage_vec
  import dsp_pkg::*;
#(
  parameter int REG_WIDTH = DSP_REG_WIDTH,
  parameter int VECTOR    = DSP_VECTOR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             clr,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0] a_d,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0] b_d,
  input  logic                             vld_d,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] a_q,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] b_q,
  output logic                             vld_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else if (clr) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else if (en) begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/delay_line_vec.sv
// Runtime-selectable 1..DEPTH cycle delay for paired sample vectors, with stall, flush,
// valid tracking and a primed flag; output is a combinational tap of the stage registers.
module delay_line_vec
  import dsp_pkg::*;
#(
  parameter int   REG_WIDTH = DSP_REG_WIDTH,
  parameter int   VECTOR    = DSP_VECTOR,
  parameter int   DEPTH     = 4,
  localparam int  DLY_W     = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0] a_in,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0] b_in,
  input  logic [DLY_W-1:0]                 dly_sel,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] a_out,
  output logic [VECTOR-1:0][REG_WIDTH-1:0] b_out,
  output logic                             out_valid,
  output logic                             primed
);

  logic [VECTOR-1:0][REG_WIDTH-1:0] a_d   [DEPTH];
  logic [VECTOR-1:0][REG_WIDTH-1:0] b_d   [DEPTH];
  logic [VECTOR-1:0][REG_WIDTH-1:0] a_stg [DEPTH];
  logic [VECTOR-1:0][REG_WIDTH-1:0] b_stg [DEPTH];
  logic [DEPTH-1:0]                 vld_d;
  logic [DEPTH-1:0]                 vld_stg;
  logic [DLY_W-1:0]                 keff;
  logic [DLY_W-1:0]                 fill_cnt;

  // Bubbles enter as zero data so stale samples never leak out of an invalid tap.
  assign a_d[0]   = in_valid ? a_in : '0;
  assign b_d[0]   = in_valid ? b_in : '0;
  assign vld_d[0] = in_valid;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign a_d[i]   = a_stg[i-1];
    assign b_d[i]   = b_stg[i-1];
    assign vld_d[i] = vld_stg[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    delay_stage_vec #(
      .REG_WIDTH (REG_WIDTH),
      .VECTOR    (VECTOR)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .clr   (clr),
      .a_d   (a_d[i]),
      .b_d   (b_d[i]),
      .vld_d (vld_d[i]),
      .a_q   (a_stg[i]),
      .b_q   (b_stg[i]),
      .vld_q (vld_stg[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (clr) begin
      fill_cnt <= '0;
    end else if (en && in_valid && (fill_cnt != DLY_W'(DEPTH))) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  assign keff   = DLY_W'(clamp_dly(32'(dly_sel), DEPTH));
  assign primed = (fill_cnt >= keff);

  always_comb begin
    a_out     = '0;
    b_out     = '0;
    out_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DLY_W'(i + 1) == keff) begin
        a_out     = a_stg[i];
        b_out     = b_stg[i];
        out_valid = vld_stg[i];
      end
    end
  end

endmodule
